// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for the lab CPU.
// Used by the register file, the CPU control and the write-back arbiter.
package regfile_pkg;
  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 2;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     reg_data_t;

  // last_grant = 1 means req1 was served last, so req0 wins the next tie.
  localparam logic LAST_GRANT_RST = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; last_grant advances only when a grant is taken.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (req[0] && req[1])
      grant = last_grant ? 2'b01 : 2'b10;
    else
      grant = req;
  end

  always_ff @(posedge clk) begin
    if (reset)
      last_grant <= LAST_GRANT_RST;
    else if (update)
      last_grant <= grant[1];
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port, with a
// load-destination scoreboard that stalls decode on stale reads.
module regfile_wb_arbiter #(
  parameter int DATA_W     = regfile_pkg::DATA_W,
  parameter int REG_ADDR_W = regfile_pkg::REG_ADDR_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [REG_ADDR_W-1:0]      req0_addr,
  input  logic [DATA_W-1:0]          req0_data,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [REG_ADDR_W-1:0]      req1_addr,
  input  logic [DATA_W-1:0]          req1_data,
  input  logic                       pend_set,
  input  logic [REG_ADDR_W-1:0]      pend_addr,
  input  logic [REG_ADDR_W-1:0]      rs1_addr,
  input  logic [REG_ADDR_W-1:0]      rs2_addr,
  input  logic                       rs1_used,
  input  logic                       rs2_used,
  output logic                       stall,
  output logic [(2**REG_ADDR_W)-1:0] pending,
  output logic                       rf_reg_write,
  output logic [REG_ADDR_W-1:0]      rf_write_reg,
  output logic [DATA_W-1:0]          rf_write_data
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  logic [1:0]            grant;
  logic [1:0]            ready_p0;
  logic                  xfer_p0;
  logic [REG_ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0]     data_p0;

  logic                  vld_p1;
  logic [REG_ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0]     data_p1;

  logic [NUM_REGS-1:0]   pending_q;
  logic [NUM_REGS-1:0]   pending_d;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({req1_valid, req0_valid}),
    .update (xfer_p0),
    .grant  (grant)
  );

  // p0: request selection; nothing is accepted while reset is held
  assign ready_p0   = reset ? 2'b00 : grant;
  assign xfer_p0    = |ready_p0;
  assign req0_ready = ready_p0[0];
  assign req1_ready = ready_p0[1];
  assign addr_p0    = ready_p0[1] ? req1_addr : req0_addr;
  assign data_p0    = ready_p0[1] ? req1_data : req0_data;

  // p1: registered register-file write port
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= xfer_p0;
      if (xfer_p0) begin
        addr_p1 <= addr_p0;
        data_p1 <= data_p0;
      end
    end
  end

  assign rf_reg_write  = vld_p1;
  assign rf_write_reg  = addr_p1;
  assign rf_write_data = data_p1;

  // Clear on commit first, then set, so a same-edge set on the same bit wins.
  always_comb begin
    pending_d = pending_q;
    if (vld_p1)
      pending_d[addr_p1] = 1'b0;
    if (pend_set)
      pending_d[pend_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      pending_q <= '0;
    else
      pending_q <= pending_d;
  end

  assign pending = pending_q;
  assign stall   = (rs1_used && pending_q[rs1_addr]) ||
                   (rs2_used && pending_q[rs2_addr]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready;
  logic [1:0]  req0_addr;
  logic [15:0] req0_data;
  logic        req1_valid, req1_ready;
  logic [1:0]  req1_addr;
  logic [15:0] req1_data;
  logic        pend_set;
  logic [1:0]  pend_addr;
  logic [1:0]  rs1_addr, rs2_addr;
  logic        rs1_used, rs2_used;
  logic        stall;
  logic [3:0]  pending;
  logic        rf_reg_write;
  logic [1:0]  rf_write_reg;
  logic [15:0] rf_write_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(16), .REG_ADDR_W(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_addr     (req0_addr),
    .req0_data     (req0_data),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_addr     (req1_addr),
    .req1_data     (req1_data),
    .pend_set      (pend_set),
    .pend_addr     (pend_addr),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_used      (rs1_used),
    .rs2_used      (rs2_used),
    .stall         (stall),
    .pending       (pending),
    .rf_reg_write  (rf_reg_write),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data)
  );

  // Advance past the next rising edge; inputs change and outputs settle after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_addr = 0; req0_data = 0;
    req1_valid = 0; req1_addr = 0; req1_data = 0;
    pend_set = 0; pend_addr = 0;
    rs1_addr = 0; rs2_addr = 0; rs1_used = 0; rs2_used = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    req0_valid = 1; req1_valid = 1;
    step();
    #1;
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
    end
    step();
    idle_inputs();
    reset = 0;
    #1;
    n_tests++;
    if (rf_reg_write !== 1'b0 || rf_write_reg !== 2'd0 || rf_write_data !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_rf: got we=%b reg=%0d data=%h want 0 0 0000",
               rf_reg_write, rf_write_reg, rf_write_data);
    end
    n_tests++;
    if (pending !== 4'b0000 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_sb: got pending=%b stall=%b want 0000 0", pending, stall);
    end
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1; req0_addr = 2; req0_data = 16'h1234;
    #1;
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_ready: got r0r1=%b want 10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 0;
    #1;
    n_tests++;
    if (rf_reg_write !== 1'b1 || rf_write_reg !== 2'd2 || rf_write_data !== 16'h1234) begin
      n_fail++;
      $display("FAIL single_write: got we=%b reg=%0d data=%h want 1 2 1234",
               rf_reg_write, rf_write_reg, rf_write_data);
    end
    step();
    n_tests++;
    if (rf_reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drop: got we=%b want 0", rf_reg_write);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_data;
    logic [1:0]  exp_rdy;
    do_reset();
    req0_valid = 1; req0_addr = 0; req0_data = 16'hAAAA;
    req1_valid = 1; req1_addr = 1; req1_data = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      exp_rdy  = (i % 2 == 0) ? 2'b10 : 2'b01;
      exp_data = (i % 2 == 0) ? 16'hAAAA : 16'h5555;
      #1;
      n_tests++;
      if ({req0_ready, req1_ready} !== exp_rdy) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got r0r1=%b want %b", i, {req0_ready, req1_ready}, exp_rdy);
      end
      step();
      n_tests++;
      if (rf_reg_write !== 1'b1 || rf_write_data !== exp_data) begin
        n_fail++;
        $display("FAIL rr_write%0d: got we=%b data=%h want 1 %h",
                 i, rf_reg_write, rf_write_data, exp_data);
      end
    end
    req0_valid = 0; req1_valid = 0;
    step();
    n_tests++;
    if (rf_reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_drop: got we=%b want 0", rf_reg_write);
    end
  endtask

  task automatic test_collision();
    do_reset();
    req0_valid = 1; req0_addr = 3; req0_data = 16'h0001;
    req1_valid = 1; req1_addr = 3; req1_data = 16'h0002;
    #1;
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL coll_first: got r0r1=%b want 10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 0;
    #1;
    n_tests++;
    if (rf_reg_write !== 1'b1 || rf_write_reg !== 2'd3 || rf_write_data !== 16'h0001
        || req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_w1: got we=%b reg=%0d data=%h r1=%b want 1 3 0001 1",
               rf_reg_write, rf_write_reg, rf_write_data, req1_ready);
    end
    step();
    req1_valid = 0;
    #1;
    n_tests++;
    if (rf_reg_write !== 1'b1 || rf_write_reg !== 2'd3 || rf_write_data !== 16'h0002) begin
      n_fail++;
      $display("FAIL coll_w2: got we=%b reg=%0d data=%h want 1 3 0002",
               rf_reg_write, rf_write_reg, rf_write_data);
    end
  endtask

  task automatic test_scoreboard();
    do_reset();
    pend_set = 1; pend_addr = 1;
    step();
    pend_set = 0;
    rs1_addr = 1; rs1_used = 1; rs2_addr = 3; rs2_used = 1;
    #1;
    n_tests++;
    if (pending !== 4'b0010 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_set: got pending=%b stall=%b want 0010 1", pending, stall);
    end
    rs1_used = 0;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_unused: got stall=%b want 0", stall);
    end
    rs1_used = 1;
    req1_valid = 1; req1_addr = 1; req1_data = 16'hBEEF;
    #1;
    n_tests++;
    if (req1_ready !== 1'b1 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_accept: got r1=%b stall=%b want 1 1", req1_ready, stall);
    end
    step();
    req1_valid = 0;
    #1;
    n_tests++;
    if (rf_reg_write !== 1'b1 || rf_write_reg !== 2'd1 || pending !== 4'b0010 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_commit: got we=%b reg=%0d pending=%b stall=%b want 1 1 0010 1",
               rf_reg_write, rf_write_reg, pending, stall);
    end
    step();
    n_tests++;
    if (pending !== 4'b0000 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_clear: got pending=%b stall=%b want 0000 0", pending, stall);
    end
    rs1_used = 0; rs2_used = 0;
  endtask

  task automatic test_set_clear();
    do_reset();
    req0_valid = 1; req0_addr = 0; req0_data = 16'h0007;
    step();
    req0_valid = 0;
    pend_set = 1; pend_addr = 0;
    step();
    pend_set = 0;
    #1;
    n_tests++;
    if (pending !== 4'b0001) begin
      n_fail++;
      $display("FAIL set_wins: got pending=%b want 0001", pending);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pend_set = 1; pend_addr = 2;
    step();
    pend_set = 0;
    req0_valid = 1; req0_addr = 1; req0_data = 16'h0055;
    step();
    req0_valid = 0;
    reset = 1;
    step();
    n_tests++;
    if (rf_reg_write !== 1'b0 || pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_clear: got we=%b pending=%b want 0 0000", rf_reg_write, pending);
    end
    reset = 0;
    step();
    n_tests++;
    if (rf_reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_nowrite: got we=%b want 0", rf_reg_write);
    end
    req0_valid = 1; req1_valid = 1; req0_addr = 0; req1_addr = 1;
    #1;
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL midrst_grant: got r0r1=%b want 10", {req0_ready, req1_ready});
    end
    step();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_single();
    test_round_robin();
    test_collision();
    test_scoreboard();
    test_set_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and hazard scoreboard for the 4-entry, 16-bit register file of the lab CPU. Two write-back requesters (ALU result path, memory-load path) share the register file's single write port through valid/ready handshakes. The block registers the winning write and drives the register file's `reg_write`, `write_reg` and `write_data` inputs. It also tracks outstanding load destinations and raises a stall when a decode-stage read would see a stale value.

## Interface
Parameters:
- `DATA_W`, 16, register data width
- `REG_ADDR_W`, 2, register address width; `NUM_REGS = 2**REG_ADDR_W`

Ports:
- `clk`  in  1  single clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high reset
- `req0_valid`  in  1  ALU write-back request
- `req0_ready`  out  1  ALU request accepted this cycle
- `req0_addr`  in  REG_ADDR_W  ALU destination register
- `req0_data`  in  DATA_W  ALU result
- `req1_valid` / `req1_ready` / `req1_addr` / `req1_data`  same widths  memory-load write-back request
- `pend_set`  in  1  load issued; mark `pend_addr` pending
- `pend_addr`  in  REG_ADDR_W  destination of the issued load
- `rs1_addr`, `rs2_addr`  in  REG_ADDR_W  decode-stage source registers
- `rs1_used`, `rs2_used`  in  1  the instruction actually reads that source
- `stall`  out  1  combinational hazard indication to the decode stage
- `pending`  out  NUM_REGS  registered scoreboard, one bit per register
- `rf_reg_write`  out  1  register-file write enable (registered)
- `rf_write_reg`  out  REG_ADDR_W  register-file write address (registered)
- `rf_write_data`  out  DATA_W  register-file write data (registered)

## Operation
- Handshake: a beat transfers on `reqN_valid && reqN_ready` at the rising edge. A requester holds addr/data stable while valid and not ready. Valid must not drop before transfer.
- Arbitration: 2-way round robin on a `last_grant` bit.
  - One valid requester: it is granted.
  - Both valid: the requester not granted last is granted.
  - `last_grant` updates only on a transfer.
  - `ready` is combinational from both valids and `last_grant`. Never both ready in one cycle.
- Output stage: an accepted beat is loaded into `rf_*` at the edge. `rf_reg_write` = 1 for exactly the following cycle, then 0 unless another beat was accepted. The output stage never back-pressures; one write per cycle is sustained.
- Same-address collision: both requests target the same register. They serialize in grant order. The later write lands one cycle after the earlier one and wins.
- Scoreboard:
  - `pend_set` sets `pending[pend_addr]` at the edge.
  - A committing write (`rf_reg_write` high for address a) clears `pending[a]` at the same edge the register file writes.
  - Simultaneous set and clear on the same address: set wins.
  - Set on an already-pending bit is a no-op.
- `stall = (rs1_used && pending[rs1_addr]) || (rs2_used && pending[rs2_addr])`.
  - During the commit cycle the bit is still 1, so a combinational read never returns the pre-write value.
- Reset behaviour:
  - All `rf_*` = 0, `pending` = 0, `last_grant` = 1 (req0 wins the first contention), `stall` = 0.
  - Reset asserted mid-operation drops any in-flight output beat; no write occurs in the cycle following reset.
  - `ready` outputs are 0 while `reset` is high.

## Timing
- Accept edge T → `rf_reg_write` high during cycle T+1 → register file updated at edge T+2.
- `pending` clear latency: bit reads 0 from cycle T+2.
- `stall` is combinational from registered state plus decode inputs, with no internal input-to-output loop.
- `ready` is combinational from valids; requesters must not make `valid` depend on `ready`.

## Structure
- Shared package `regfile_pkg`: `DATA_W`, `REG_ADDR_W`, `NUM_REGS` constants and the `reg_addr_t` / `reg_data_t` typedefs, reused by the register file and the CPU control.
- One sub-module, `rr_arbiter2`: two request inputs, `last_grant` state, one-hot grant output, update-on-transfer input.
- Top level holds the output stage, scoreboard and stall logic.

## Test plan
- Reset, then a single req0 (addr 2, data 16'h1234) → `req0_ready` = 1. Next cycle `rf_reg_write` = 1, `rf_write_reg` = 2, `rf_write_data` = 16'h1234. The cycle after, `rf_reg_write` = 0.
- Both valid every cycle for 4 cycles (req0 data 16'hAAAA, req1 data 16'h5555) → grants alternate req0, req1, req0, req1. `rf_reg_write` stays high for 4 consecutive cycles.
- Both valid to addr 3 (req0 16'h0001, req1 16'h0002) after reset → req0 first. Final `rf_write_data` to register 3 is 16'h0002.
- `pend_set` addr 1, then decode with `rs1_addr` = 1, `rs1_used` = 1 → `stall` = 1. Load write-back to addr 1 is accepted → `stall` remains 1 through the commit cycle and drops when `pending[1]` clears. With `rs1_used` = 0, `stall` = 0 throughout.
- `pend_set` addr 0 in the same cycle that `rf_reg_write` commits addr 0 → `pending[0]` stays 1.
- Accept a beat, then assert `reset` the next cycle → `rf_reg_write` = 0, `pending` = 0, and no register-file write occurs. The first contention after reset grants req0.
